kamacore_hazard_controller: RTL and testbench

Central pipeline sequencer for the five-stage kamacore pipeline (IF, ID, EX, MEM, WB). It watches the register addresses and control bits carried in each stage register and produces per-stage hold/flush strobes, EX-operand forwarding selects, and the data-memory request handshake. It also runs a memory-wait state machine with timeout detection and a saturating stall-cycle counter.

---
 rtl/kamacore_pkg.sv | 19 +
 rtl/kamacore_forward_unit.sv | 28 ++
 rtl/kamacore_hazard_controller.sv | 151 +++++++++++++++
 tb/tb_kamacore_hazard_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared widths and enumerations for the kamacore pipeline control blocks.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/kamacore_forward_unit.sv
// EX operand bypass select for one source register; MEM beats WB, loads in MEM cannot forward.
module kamacore_forward_unit
  import kamacore_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] mem_destination_register,
  input  logic                      mem_control_write_register,
  input  logic                      mem_control_memory_read,
  input  logic [REG_ADDR_WIDTH-1:0] wb_destination_register,
  input  logic                      wb_control_write_register,
  output logic [1:0]                fwd_sel
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (mem_control_write_register && !mem_control_memory_read &&
        (mem_destination_register != '0) && (mem_destination_register == ex_rs_addr))
      sel = FWD_MEM;
    else if (wb_control_write_register && (wb_destination_register != '0) &&
             (wb_destination_register == ex_rs_addr))
      sel = FWD_WB;
  end

  assign fwd_sel = sel;

endmodule

// File: rtl/kamacore_hazard_controller.sv
// Pipeline sequencer: hold/flush strobes, forwarding selects, data-memory wait FSM with timeout.
module kamacore_hazard_controller
  import kamacore_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] ex_destination_register,
  input  logic                      ex_control_memory_read,
  input  logic                      ex_control_write_register,
  input  logic                      branch_taken,
  input  logic [REG_ADDR_WIDTH-1:0] mem_destination_register,
  input  logic                      mem_control_memory_read,
  input  logic                      mem_control_memory_write,
  input  logic                      mem_control_write_register,
  input  logic [REG_ADDR_WIDTH-1:0] wb_destination_register,
  input  logic                      wb_control_write_register,
  input  logic                      dmem_ready,
  output logic                      dmem_req,
  output logic                      hold_if,
  output logic                      hold_id,
  output logic                      hold_ex,
  output logic                      hold_mem,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      flush_wb,
  output logic [1:0]                fwd_rs1_sel,
  output logic [1:0]                fwd_rs2_sel,
  output logic                      mem_timeout,
  output logic [31:0]               stall_cycles
);

  hazard_state_e state, state_next;
  logic [15:0]   wait_cnt;
  logic          mem_access, mem_busy, load_use;
  logic          mem_stall, flow_eval;

  assign mem_access = mem_control_memory_read | mem_control_memory_write;
  assign mem_busy   = mem_access & ~dmem_ready;
  assign load_use   = ex_control_memory_read & ex_control_write_register &
                      (ex_destination_register != '0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_destination_register)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_destination_register)));

  // Branch/load-use are only acted on when MEM is not stalling, including the
  // cycle a pending access completes, so a frozen EX re-evaluates after the wait.
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    flow_eval  = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          mem_stall  = 1'b1;
          state_next = MEM_WAIT;
        end else begin
          flow_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          mem_stall = 1'b1;
          if (wait_cnt == MEM_TIMEOUT[15:0]) state_next = ERROR;
        end else begin
          flow_eval  = 1'b1;
          state_next = RUN;
        end
      end
      ERROR:   mem_stall = 1'b1;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    dmem_req = mem_access && (state != ERROR);
    hold_if  = mem_stall;
    hold_id  = mem_stall;
    hold_ex  = mem_stall;
    hold_mem = mem_stall;
    flush_wb = mem_stall;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (flow_eval) begin
      if (branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        hold_if  = 1'b1;
        hold_id  = 1'b1;
        flush_ex = 1'b1;
      end
    end
    if (rst) begin
      dmem_req = 1'b0;
      hold_if  = 1'b0;
      hold_id  = 1'b0;
      hold_ex  = 1'b0;
      hold_mem = 1'b0;
      flush_wb = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (state == RUN && mem_busy)
        wait_cnt <= 16'd1;
      else if (state == MEM_WAIT && !dmem_ready)
        wait_cnt <= wait_cnt + 16'd1;
      if (state_next == ERROR)
        mem_timeout <= 1'b1;
      if (hold_if && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  kamacore_forward_unit u_fwd_rs1 (
    .ex_rs_addr                 (ex_rs1_addr),
    .mem_destination_register   (mem_destination_register),
    .mem_control_write_register (mem_control_write_register),
    .mem_control_memory_read    (mem_control_memory_read),
    .wb_destination_register    (wb_destination_register),
    .wb_control_write_register  (wb_control_write_register),
    .fwd_sel                    (fwd_rs1_sel)
  );

  kamacore_forward_unit u_fwd_rs2 (
    .ex_rs_addr                 (ex_rs2_addr),
    .mem_destination_register   (mem_destination_register),
    .mem_control_write_register (mem_control_write_register),
    .mem_control_memory_read    (mem_control_memory_read),
    .wb_destination_register    (wb_destination_register),
    .wb_control_write_register  (wb_control_write_register),
    .fwd_sel                    (fwd_rs2_sel)
  );

endmodule

// File: tb/tb_kamacore_hazard_controller.sv
// Directed and randomized bench for kamacore_hazard_controller against a cycle-level behavioural model.
module tb_kamacore_hazard_controller;
  import kamacore_pkg::*;

  localparam int unsigned TIMEOUT = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] ex_destination_register, mem_destination_register, wb_destination_register;
  logic id_uses_rs1, id_uses_rs2, ex_control_memory_read, ex_control_write_register, branch_taken;
  logic mem_control_memory_read, mem_control_memory_write, mem_control_write_register;
  logic wb_control_write_register, dmem_ready;
  logic dmem_req, hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, flush_wb, mem_timeout;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cycles;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: whether an access is outstanding, how many wait cycles it has
  // accumulated, whether the block is locked up, and total stalled cycles.
  bit          m_waiting, m_locked;
  int unsigned m_waited;
  longint unsigned m_stalls;

  always #5 clk = ~clk;

  kamacore_hazard_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_destination_register(ex_destination_register),
    .ex_control_memory_read(ex_control_memory_read),
    .ex_control_write_register(ex_control_write_register),
    .branch_taken(branch_taken),
    .mem_destination_register(mem_destination_register),
    .mem_control_memory_read(mem_control_memory_read),
    .mem_control_memory_write(mem_control_memory_write),
    .mem_control_write_register(mem_control_write_register),
    .wb_destination_register(wb_destination_register),
    .wb_control_write_register(wb_control_write_register),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex), .hold_mem(hold_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (mem_control_write_register && !mem_control_memory_read &&
        mem_destination_register != 0 && mem_destination_register == rs) return 2'd1;
    if (wb_control_write_register && wb_destination_register != 0 &&
        wb_destination_register == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Compare every output with the model, then advance the model across the coming edge.
  task automatic run_cycle();
    bit e_req, e_stall, e_hif, e_hid, e_fid, e_fex, lu, acc;
    @(negedge clk);
    acc = mem_control_memory_read || mem_control_memory_write;
    lu  = ex_control_memory_read && ex_control_write_register && ex_destination_register != 0 &&
          ((id_uses_rs1 && id_rs1_addr == ex_destination_register) ||
           (id_uses_rs2 && id_rs2_addr == ex_destination_register));
    e_req = 0; e_stall = 0; e_hif = 0; e_hid = 0; e_fid = 0; e_fex = 0;
    if (!rst) begin
      e_req = acc && !m_locked;
      if (m_locked || (acc && !dmem_ready) || (m_waiting && !dmem_ready)) e_stall = 1;
      else if (branch_taken) begin e_fid = 1; e_fex = 1; end
      else if (lu) begin e_hif = 1; e_hid = 1; e_fex = 1; end
    end
    e_hif = e_hif || e_stall;
    e_hid = e_hid || e_stall;
    check("dmem_req", dmem_req, e_req);
    check("hold_if", hold_if, e_hif);
    check("hold_id", hold_id, e_hid);
    check("hold_ex", hold_ex, e_stall);
    check("hold_mem", hold_mem, e_stall);
    check("flush_wb", flush_wb, e_stall);
    check("flush_id", flush_id, e_fid);
    check("flush_ex", flush_ex, e_fex);
    check("fwd_rs1", fwd_rs1_sel, fwd_model(ex_rs1_addr));
    check("fwd_rs2", fwd_rs2_sel, fwd_model(ex_rs2_addr));
    check("mem_timeout", mem_timeout, m_locked);
    check("stall_cycles", stall_cycles, (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stalls[31:0]);
    if (rst) begin
      m_waiting = 0; m_locked = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (e_hif) m_stalls++;
      if (m_waiting) begin
        if (dmem_ready) m_waiting = 0;
        else if (m_waited == TIMEOUT) begin m_waiting = 0; m_locked = 1; end
        else m_waited++;
      end else if (!m_locked && acc && !dmem_ready) begin
        m_waiting = 1; m_waited = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr} = '0;
    {ex_destination_register, mem_destination_register, wb_destination_register} = '0;
    {id_uses_rs1, id_uses_rs2, ex_control_memory_read, ex_control_write_register, branch_taken} = '0;
    {mem_control_memory_read, mem_control_memory_write, mem_control_write_register} = '0;
    wb_control_write_register = 1'b0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_waiting = 0; m_locked = 0; m_waited = 0; m_stalls = 0;
    @(posedge clk); #1;
    run_cycle();
    rst = 1'b0;
    check("reset_stall_cycles", stall_cycles, 32'd0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID, then EX becomes a bubble.
    ex_control_memory_read = 1; ex_control_write_register = 1; ex_destination_register = 5;
    id_rs1_addr = 5; id_rs2_addr = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    #1 check("lu_hold_if", hold_if, 1'b1);
    run_cycle();
    ex_control_memory_read = 0; ex_control_write_register = 0; ex_destination_register = 0;
    #1 check("lu_released", hold_if, 1'b0);
    run_cycle();
    check("lu_stall_count", stall_cycles, 32'd1);
    ex_control_memory_read = 1; ex_control_write_register = 1; id_rs1_addr = 0;
    #1 check("lu_x0_no_stall", hold_if, 1'b0);
    run_cycle();
    idle_inputs();

    // Forwarding priority.
    ex_rs1_addr = 3; mem_destination_register = 3; mem_control_write_register = 1;
    wb_destination_register = 3; wb_control_write_register = 1;
    #1 check("fwd_mem_pri", fwd_rs1_sel, 2'd1);
    run_cycle();
    mem_control_memory_read = 1;
    #1 check("fwd_load_wb", fwd_rs1_sel, 2'd2);
    run_cycle();
    ex_rs1_addr = 0; mem_destination_register = 0; wb_destination_register = 0;
    #1 check("fwd_x0", fwd_rs1_sel, 2'd0);
    run_cycle();
    idle_inputs();

    // Store waits three cycles.
    do_reset();
    mem_control_memory_write = 1; dmem_ready = 0;
    repeat (3) begin
      #1 check("wait_req", dmem_req, 1'b1);
      run_cycle();
    end
    dmem_ready = 1;
    #1 check("wait_done_hold", hold_mem, 1'b0);
    run_cycle();
    mem_control_memory_write = 0;
    check("wait_stall_count", stall_cycles, 32'd3);
    mem_control_memory_read = 1;
    #1 check("ready_first_no_stall", hold_if, 1'b0);
    run_cycle();
    check("ready_first_count", stall_cycles, 32'd3);
    idle_inputs();

    // Branch beats load-use; memory stall beats branch until ready.
    ex_control_memory_read = 1; ex_control_write_register = 1; ex_destination_register = 7;
    id_rs2_addr = 7; id_uses_rs2 = 1; branch_taken = 1;
    #1 check("br_lu_flush_id", flush_id, 1'b1);
    check("br_lu_hold_if", hold_if, 1'b0);
    run_cycle();
    idle_inputs();
    branch_taken = 1; mem_control_memory_write = 1; dmem_ready = 0;
    #1 check("busy_br_no_flush", flush_id, 1'b0);
    run_cycle();
    run_cycle();
    dmem_ready = 1;
    #1 check("busy_br_flush_on_ready", flush_id, 1'b1);
    run_cycle();
    idle_inputs();

    // Timeout lockup and recovery.
    mem_control_memory_write = 1; dmem_ready = 0;
    repeat (7) run_cycle();
    check("to_flag", mem_timeout, 1'b1);
    check("to_req", dmem_req, 1'b0);
    check("to_hold", hold_mem, 1'b1);
    dmem_ready = 1;
    run_cycle();
    check("to_sticky", hold_if, 1'b1);
    do_reset();
    idle_inputs();
    #1 check("to_cleared", mem_timeout, 1'b0);
    check("to_cleared_hold", hold_if, 1'b0);
    run_cycle();

    // Reset during the second wait cycle abandons the access.
    mem_control_memory_read = 1; dmem_ready = 0;
    run_cycle();
    run_cycle();
    rst = 1;
    run_cycle();
    rst = 0;
    idle_inputs();
    #1 check("midwait_stall", stall_cycles, 32'd0);
    check("midwait_hold", hold_if, 1'b0);
    run_cycle();

    // Randomized traffic over a small register set so hazards collide often.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(59) == 0);
      id_rs1_addr = REG_ADDR_WIDTH'($urandom_range(3));
      id_rs2_addr = REG_ADDR_WIDTH'($urandom_range(3));
      ex_rs1_addr = REG_ADDR_WIDTH'($urandom_range(3));
      ex_rs2_addr = REG_ADDR_WIDTH'($urandom_range(3));
      ex_destination_register  = REG_ADDR_WIDTH'($urandom_range(3));
      mem_destination_register = REG_ADDR_WIDTH'($urandom_range(3));
      wb_destination_register  = REG_ADDR_WIDTH'($urandom_range(3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_control_memory_read = 1'($urandom); ex_control_write_register = 1'($urandom);
      branch_taken = ($urandom_range(4) == 0);
      mem_control_memory_read  = ($urandom_range(3) == 0);
      mem_control_memory_write = ($urandom_range(3) == 0);
      mem_control_write_register = 1'($urandom);
      wb_control_write_register  = 1'($urandom);
      dmem_ready = ($urandom_range(2) != 0);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
